// File: rtl/mealy_detect_scheduler_pkg.sv
// Shared types and constants for the time-multiplexed "two consecutive 1s" detector.
// The per-channel counter feature is built only when MEALY_SCHED_CNT_EN is defined.
package mealy_sched_pkg;

   typedef enum logic {
      ST_A = 1'b0,
      ST_B = 1'b1
   } state_t;

   localparam int NCH_DEF   = 4;
   localparam int CNT_W_DEF = 8;

   function automatic int ch_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mealy_detect_scheduler_if.sv
// Bundle between the serial bit sources / event logic (master) and the scheduler (slave).
interface mealy_detect_scheduler_if
   import mealy_sched_pkg::*;
#(
   parameter int NCH   = NCH_DEF,
   parameter int CNT_W = CNT_W_DEF
);
   logic [NCH-1:0]         req;
   logic [NCH-1:0]         bit_in;
   logic [NCH-1:0]         chan_clr;
   logic [NCH-1:0]         gnt;
   logic                   det_valid;
   logic [ch_w(NCH)-1:0]   det_ch;
   logic [NCH*CNT_W-1:0]   det_cnt;

   modport master (
      output req, bit_in, chan_clr,
      input  gnt, det_valid, det_ch, det_cnt
   );

   modport slave (
      input  req, bit_in, chan_clr,
      output gnt, det_valid, det_ch, det_cnt
   );
endinterface

// File: rtl/mealy_detect_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after ptr, wrapping.
module rr_arbiter
   import mealy_sched_pkg::*;
#(
   parameter int NCH = NCH_DEF
) (
   input  logic [NCH-1:0]       req,
   input  logic [ch_w(NCH)-1:0] ptr,
   output logic [NCH-1:0]       gnt
);

   logic found;

   always_comb begin
      gnt   = '0;
      found = 1'b0;
      // Walk offsets from ptr; only one channel index matches each offset.
      for (int i = 0; i < NCH; i++) begin
         for (int k = 0; k < NCH; k++) begin
            if (!found && (k == ((int'(ptr) + i) % NCH)) && req[k]) begin
               gnt[k] = 1'b1;
               found  = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/mealy_detect_scheduler.sv
// One shared Mealy "11" detector serving NCH channels through a round-robin arbiter.
// Per-channel saturating counters are built only when MEALY_SCHED_CNT_EN is defined.
module mealy_detect_scheduler
   import mealy_sched_pkg::*;
#(
   parameter int NCH   = NCH_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input logic                     clk,
   input logic                     areset,
   mealy_detect_scheduler_if.slave bus
);

   localparam int CW = ch_w(NCH);

   logic [NCH-1:0]       gnt;
   logic                 any_gnt;
   logic [CW-1:0]        gidx;
   logic                 det;
   logic [CW-1:0]        ptr_q, ptr_d;
   state_t               st_q [NCH];
   state_t               st_d [NCH];
   logic                 det_valid_q, det_valid_d;
   logic [CW-1:0]        det_ch_q, det_ch_d;
   logic [NCH*CNT_W-1:0] det_cnt;

   rr_arbiter #(.NCH(NCH)) u_arb (
      .req (bus.req),
      .ptr (ptr_q),
      .gnt (gnt)
   );

   always_comb begin
      any_gnt = |gnt;
      gidx    = '0;
      for (int k = 0; k < NCH; k++) begin
         if (gnt[k]) gidx = CW'(k);
      end

      // A clear on the granted channel consumes the grant but discards the bit.
      det = any_gnt && !bus.chan_clr[gidx] && (st_q[gidx] == ST_B) && bus.bit_in[gidx];

      st_d = st_q;
      if (any_gnt) st_d[gidx] = bus.bit_in[gidx] ? ST_B : ST_A;
      for (int k = 0; k < NCH; k++) begin
         if (bus.chan_clr[k]) st_d[k] = ST_A;
      end

      ptr_d = ptr_q;
      if (any_gnt) ptr_d = (gidx == CW'(NCH - 1)) ? '0 : gidx + CW'(1);

      det_valid_d = det;
      det_ch_d    = det ? gidx : det_ch_q;
   end

   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         ptr_q       <= '0;
         det_valid_q <= 1'b0;
         det_ch_q    <= '0;
         for (int k = 0; k < NCH; k++) st_q[k] <= ST_A;
      end else begin
         ptr_q       <= ptr_d;
         det_valid_q <= det_valid_d;
         det_ch_q    <= det_ch_d;
         st_q        <= st_d;
      end
   end

`ifdef MEALY_SCHED_CNT_EN
   logic [CNT_W-1:0] cnt_q [NCH];
   logic [CNT_W-1:0] cnt_d [NCH];

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   always_comb begin
      det_cnt = '0;
      for (int k = 0; k < NCH; k++) begin
         cnt_d[k] = cnt_q[k];
         if (bus.chan_clr[k])                 cnt_d[k] = '0;
         else if (det && (gidx == CW'(k)))    cnt_d[k] = sat_inc(cnt_q[k]);
         det_cnt[k*CNT_W +: CNT_W] = cnt_q[k];
      end
   end

   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         for (int k = 0; k < NCH; k++) cnt_q[k] <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
`else
   assign det_cnt = '0;
`endif

   assign bus.gnt       = gnt;
   assign bus.det_valid = det_valid_q;
   assign bus.det_ch    = det_ch_q;
   assign bus.det_cnt   = det_cnt;

endmodule

// File: doc/mealy_detect_scheduler.md
# mealy_detect_scheduler

Time-multiplexes one "two consecutive 1s" Mealy detector across NCH independent serial bit channels. A round-robin arbiter picks one requesting channel per cycle. The chosen channel's saved detector state is advanced with its bit, and a registered detection pulse is emitted tagged with the channel index. The block sits between the per-channel serial sources and the downstream event logic, and replaces NCH separate detector instances.

## Interface
- NCH, 4, number of channels (2..16)
- CNT_W, 8, width of each per-channel detection counter
- clk  in  1  rising-edge clock
- areset  in  1  asynchronous, active-high reset
- req  in  NCH  per-channel request; the channel has a bit to deliver
- bit_in  in  NCH  per-channel data bit; must be valid while req is high
- chan_clr  in  NCH  synchronous per-channel clear of detector state (and counter)
- gnt  out  NCH  one-hot grant; combinational from req and the priority pointer
- det_valid  out  1  registered pulse; a detection occurred on the granted bit
- det_ch  out  $clog2(NCH)  channel index of the detection; held when det_valid is 0
- det_cnt  out  NCH*CNT_W  per-channel detection counters, flattened, channel 0 in the LSBs

## Operation
- Per-channel state st[k] is in {ST_A (last accepted bit 0 or none), ST_B (last accepted bit 1)}.
- Arbitration:
  - gnt selects the first requesting channel at or after ptr, wrapping modulo NCH.
  - gnt is all-zero when req is zero.
- Accept: channel k is accepted on an edge where gnt[k]=1.
  - Detection when st[k]=ST_B and bit_in[k]=1.
  - Next st[k] is ST_B if bit_in[k]=1, else ST_A.
  - Ungranted channels hold their state.
- Pointer: after accepting k, ptr = (k+1) mod NCH. With no grant, ptr is unchanged.
- chan_clr[k] on an edge:
  - st[k] goes to ST_A and det_cnt[k] goes to 0.
  - If k is granted in the same cycle, the grant is still consumed, the bit is discarded, and no detection is reported. ptr advances normally.
- det_valid/det_ch are registered from the accept decision. det_valid is 1 for exactly one cycle per detection.
- Counters increment on detection and saturate at 2^CNT_W-1.
- Reset values: all st = ST_A, ptr = 0, det_valid = 0, det_ch = 0, det_cnt = 0. gnt follows req combinationally, including during reset.
- Reset mid-operation: all saved states are lost. The next bits start from ST_A, so the first bit after reset can never produce a detection.

## Timing
- Throughput: one accepted bit per cycle, aggregate across all channels.
- Latency: bit accepted at edge N; det_valid is high in the cycle after edge N, cleared at edge N+1 unless another detection occurs.
- Handshake: a requester holds req and bit_in stable until it sees gnt high at a clock edge, then either drops req or presents its next bit.
- Fairness: a continuously requesting channel waits at most NCH-1 cycles.
- Back-to-back bits on the same channel are legal. Detection uses the state updated at the previous accept.

## Configuration
- MEALY_SCHED_CNT_EN defined:
  - per-channel saturating counters are implemented and drive det_cnt.
- Not defined:
  - no counter flops are built.
  - det_cnt is present and tied to 0.
  - all other behaviour is identical.

## Structure
- Package mealy_sched_pkg:
  - state typedef (ST_A=1'b0, ST_B=1'b1).
  - default NCH/CNT_W constants.
  - channel-index width function.
- Sub-module rr_arbiter:
  - parameter NCH.
  - inputs req and ptr, output one-hot gnt, combinational.
  - the top level owns the ptr register.

## Test plan
- Reset, then channel 0 alone sends 1,1,1,0,1 -> det_valid high after the 2nd and 3rd bits only, det_ch=0, det_cnt[0]=2.
- req=4'b1111 held for 8 cycles, starting from ptr=0 -> gnt sequence 0,1,2,3,0,1,2,3. Only channel 2 sends bits 1,1 -> one detection, det_ch=2.
- Interleaving isolation: channel 1 sends 1, then channel 3 sends 1, then channel 1 sends 1 -> detection on channel 1 only. Channel 3's ST_B does not leak into channel 1.
- chan_clr[1] in the same cycle channel 1 is granted with bit 1 while st[1]=ST_B -> no det_valid, st[1]=ST_A, det_cnt[1]=0, ptr=2.
- CNT_W=2 with MEALY_SCHED_CNT_EN: five detections on channel 0 -> det_cnt[0] saturates at 3.
- areset asserted asynchronously between two 1 bits on channel 0 -> outputs return to 0 immediately. The next 1 after release gives no detection; a second 1 gives a detection.
